// File: rtl/mem_wbuf_pkg.sv
// ----------------------------------------------------------------------------
// mem_wbuf_pkg
// Shared types and constants for the posted-write buffer that sits between
// direct_cache and main_mem.
//   - default geometry (address/data width, depth, memory write latency)
//   - drain/read FSM state encoding
//   - buffer entry record (valid, addr, data) at the default geometry
//   - pointer-width helper used to size the FIFO head/tail pointers
// ----------------------------------------------------------------------------
package mem_wbuf_pkg;

    localparam int unsigned WBUF_ADDR_WIDTH     = 32'd16;
    localparam int unsigned WBUF_DATA_WIDTH     = 32'd8;
    localparam int unsigned WBUF_DEPTH          = 32'd4;
    localparam int unsigned WBUF_MEM_WR_LATENCY = 32'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4
    } wbuf_state_t;

    typedef struct packed {
        logic                       valid;
        logic [WBUF_ADDR_WIDTH-1:0] addr;
        logic [WBUF_DATA_WIDTH-1:0] data;
    } wbuf_entry_t;

    // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// ----------------------------------------------------------------------------
// wbuf_fifo
// In-order storage for posted writes plus a parallel address lookup used to
// forward buffered data to cache line-fill reads.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push/push_addr/data   enqueue at tail (ignored while full)
//   pop                   dequeue head (ignored while empty)
//   lookup_addr           address compared against every valid entry
//   full, empty           occupancy flags
//   head_addr/head_data   oldest entry, the next one to drain
//   hit/hit_data          lookup result; data comes from the youngest match
// ----------------------------------------------------------------------------
module wbuf_fifo
    import mem_wbuf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WBUF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WBUF_DATA_WIDTH,
    parameter int unsigned DEPTH      = WBUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 32'd1;

    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic                  valid_r [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_r  [DEPTH];
    logic [DATA_WIDTH-1:0] data_r  [DEPTH];

    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] hit_data_s;
    logic [PTR_W-1:0]      idx_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head_addr = addr_r[head_r];
    assign head_data = data_r[head_r];
    assign hit       = hit_s;
    assign hit_data  = hit_data_s;

    // Pointers, occupancy count and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int unsigned i = 32'd0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else begin
            if (push_ok_s) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            addr_r[tail_r] <= push_addr;
            data_r[tail_r] <= push_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest write.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = {DATA_WIDTH{1'b0}};
        idx_s      = head_r;
        for (int unsigned i = 32'd0; i < DEPTH; i++) begin
            idx_s = head_r + PTR_W'(i);
            if (valid_r[idx_s] && (addr_r[idx_s] == lookup_addr)) begin
                hit_s      = 1'b1;
                hit_data_s = data_r[idx_s];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// ----------------------------------------------------------------------------
// mem_write_buffer
// Posted-write buffer between direct_cache and main_mem. Cache writes are
// queued without stalling and drained in order; line-fill reads are served
// from the youngest buffered write when possible, otherwise from main_mem.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cache_addr/_addr_en/_is_rd/_wdata cache request (sampled every edge)
//   cache_rdata, cache_rdata_vld     read return, one-cycle valid pulse
//   buf_busy                         a request at this edge is ignored
//   buf_empty                        nothing queued and no memory op open
//   mem_addr/_addr_en/_we/_wdata     main_mem command, one-cycle issue pulse
//   mem_rdata, mem_rdata_vld         main_mem read return
// ----------------------------------------------------------------------------
module mem_write_buffer
    import mem_wbuf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = WBUF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = WBUF_DATA_WIDTH,
    parameter int unsigned DEPTH          = WBUF_DEPTH,
    parameter int unsigned MEM_WR_LATENCY = WBUF_MEM_WR_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_addr_en,
    input  logic                  cache_is_rd,
    input  logic [DATA_WIDTH-1:0] cache_wdata,
    output logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  cache_rdata_vld,
    output logic                  buf_busy,
    output logic                  buf_empty,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_addr_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdata_vld
);

    // Counter holds MEM_WR_LATENCY-1 at most.
    localparam int unsigned LAT_W = (MEM_WR_LATENCY > 32'd1) ? $clog2(MEM_WR_LATENCY) : 32'd1;

    wbuf_state_t           state_r;
    logic [LAT_W-1:0]      lat_cnt_r;
    logic                  rd_pending_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [DATA_WIDTH-1:0] cache_rdata_r;
    logic                  cache_rdata_vld_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  mem_addr_en_r;
    logic                  mem_we_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] hit_data_s;
    logic                  buf_busy_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  pop_s;

    assign buf_busy_s  = fifo_full_s || rd_pending_r;
    assign wr_accept_s = cache_addr_en && !cache_is_rd && !buf_busy_s;
    assign rd_accept_s = cache_addr_en && cache_is_rd && !buf_busy_s;
    // The head entry stays visible to forwarding until this pop.
    assign pop_s       = (state_r == WR_WAIT) && (lat_cnt_r == {LAT_W{1'b0}});

    wbuf_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (wr_accept_s),
        .push_addr   (cache_addr),
        .push_data   (cache_wdata),
        .pop         (pop_s),
        .lookup_addr (cache_addr),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s),
        .head_addr   (head_addr_s),
        .head_data   (head_data_s),
        .hit         (hit_s),
        .hit_data    (hit_data_s)
    );

    // Read acceptance, drain/read sequencing and every registered output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r           <= IDLE;
            lat_cnt_r         <= {LAT_W{1'b0}};
            rd_pending_r      <= 1'b0;
            rd_addr_r         <= {ADDR_WIDTH{1'b0}};
            cache_rdata_r     <= {DATA_WIDTH{1'b0}};
            cache_rdata_vld_r <= 1'b0;
            mem_addr_r        <= {ADDR_WIDTH{1'b0}};
            mem_addr_en_r     <= 1'b0;
            mem_we_r          <= 1'b0;
            mem_wdata_r       <= {DATA_WIDTH{1'b0}};
        end else begin
            cache_rdata_vld_r <= 1'b0;
            mem_addr_en_r     <= 1'b0;
            mem_we_r          <= 1'b0;

            // A hit never touches memory; a miss is parked until the FSM is idle.
            if (rd_accept_s) begin
                if (hit_s) begin
                    cache_rdata_r     <= hit_data_s;
                    cache_rdata_vld_r <= 1'b1;
                end else begin
                    rd_pending_r <= 1'b1;
                    rd_addr_r    <= cache_addr;
                end
            end

            case (state_r)
                IDLE: begin
                    // Pending read wins over draining, but only between writes.
                    if (rd_pending_r) begin
                        state_r       <= RD_ISSUE;
                        mem_addr_en_r <= 1'b1;
                        mem_addr_r    <= rd_addr_r;
                    end else if (!fifo_empty_s) begin
                        state_r       <= WR_ISSUE;
                        mem_addr_en_r <= 1'b1;
                        mem_we_r      <= 1'b1;
                        mem_addr_r    <= head_addr_s;
                        mem_wdata_r   <= head_data_s;
                    end
                end
                WR_ISSUE: begin
                    lat_cnt_r <= LAT_W'(MEM_WR_LATENCY - 32'd1);
                    state_r   <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        state_r <= IDLE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1'b1);
                    end
                end
                RD_ISSUE: begin
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_rdata_vld) begin
                        cache_rdata_r     <= mem_rdata;
                        cache_rdata_vld_r <= 1'b1;
                        rd_pending_r      <= 1'b0;
                        state_r           <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign cache_rdata     = cache_rdata_r;
    assign cache_rdata_vld = cache_rdata_vld_r;
    assign buf_busy        = buf_busy_s;
    assign buf_empty       = fifo_empty_s && !rd_pending_r && (state_r == IDLE);
    assign mem_addr        = mem_addr_r;
    assign mem_addr_en     = mem_addr_en_r;
    assign mem_we          = mem_we_r;
    assign mem_wdata       = mem_wdata_r;

endmodule

// File: tb/tb_mem_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_mem_write_buffer
// Directed steps drive the cache side; a negedge monitor plays main_mem and
// scoreboards every memory command and every cache read return against
// queues of expectations filled when the stimulus is driven.
// ----------------------------------------------------------------------------
module tb_mem_write_buffer;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_op_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] cache_addr = '0;
    logic          cache_addr_en = 1'b0;
    logic          cache_is_rd = 1'b0;
    logic [DW-1:0] cache_wdata = '0;
    logic [DW-1:0] cache_rdata;
    logic          cache_rdata_vld;
    logic          buf_busy;
    logic          buf_empty;
    logic [AW-1:0] mem_addr;
    logic          mem_addr_en;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rdata_vld = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_op_t       exp_mem_q[$];
    logic [DW-1:0] exp_rd_q[$];

    int            cyc = 0;
    int            mem_pulses = 0;
    int            mem_rd_pulses = 0;
    int            vld_pulses = 0;
    int            last_wr_cyc = 0;
    int            last_rd_cyc = 0;
    logic          prev_en = 1'b0;
    int            rsp_cnt = -1;
    int            rsp_delay = 2;
    logic [AW-1:0] rsp_addr = '0;

    always #5 clk = ~clk;

    mem_write_buffer #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .DEPTH          (4),
        .MEM_WR_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cache_addr      (cache_addr),
        .cache_addr_en   (cache_addr_en),
        .cache_is_rd     (cache_is_rd),
        .cache_wdata     (cache_wdata),
        .cache_rdata     (cache_rdata),
        .cache_rdata_vld (cache_rdata_vld),
        .buf_busy        (buf_busy),
        .buf_empty       (buf_empty),
        .mem_addr        (mem_addr),
        .mem_addr_en     (mem_addr_en),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_rdata_vld   (mem_rdata_vld)
    );

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // main_mem model plus scoreboard for memory commands and read returns
    always @(negedge clk) begin
        mem_op_t op;
        cyc++;
        mem_rdata_vld = 1'b0;
        if (rsp_cnt > 0) rsp_cnt--;
        if (rsp_cnt == 0) begin
            mem_rdata_vld = 1'b1;
            mem_rdata     = mem_model(rsp_addr);
            rsp_cnt       = -1;
        end
        if (mem_addr_en === 1'b1) begin
            mem_pulses++;
            check("mem_en_single_cycle", 32'(prev_en), 32'd0);
            check("mem_op_expected", 32'(exp_mem_q.size() != 0), 32'd1);
            if (exp_mem_q.size() != 0) begin
                op = exp_mem_q.pop_front();
                check("mem_we", 32'(mem_we), 32'(op.we));
                check("mem_addr", 32'(mem_addr), 32'(op.addr));
                if (op.we) check("mem_wdata", 32'(mem_wdata), 32'(op.data));
            end
            if (mem_we === 1'b0) begin
                mem_rd_pulses++;
                last_rd_cyc = cyc;
                rsp_cnt     = rsp_delay;
                rsp_addr    = mem_addr;
            end else begin
                last_wr_cyc = cyc;
            end
        end
        prev_en = (mem_addr_en === 1'b1);
        if (cache_rdata_vld === 1'b1) begin
            vld_pulses++;
            check("rdata_expected", 32'(exp_rd_q.size() != 0), 32'd1);
            if (exp_rd_q.size() != 0) check("cache_rdata", 32'(cache_rdata), 32'(exp_rd_q.pop_front()));
        end
    end

    // Present one request and hold it until the buffer takes it.
    task automatic send(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        @(negedge clk);
        cache_addr_en = 1'b1;
        cache_is_rd   = rd;
        cache_addr    = a;
        cache_wdata   = d;
        waited        = 0;
        while (buf_busy !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_not_busy", 32'(buf_busy), 32'd0);
        @(posedge clk);
        #1;
        cache_addr_en = 1'b0;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_op_t op;
        op.we = 1'b1; op.addr = a; op.data = d;
        exp_mem_q.push_back(op);
    endtask

    task automatic push_rd(input logic [AW-1:0] a);
        mem_op_t op;
        op.we = 1'b0; op.addr = a; op.data = '0;
        exp_mem_q.push_back(op);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (buf_empty !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(buf_empty), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, base, base_rd, base_vld;
        logic busy_ok;

        // reset, then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_buf_empty", 32'(buf_empty), 32'd1);
            check("idle_buf_busy", 32'(buf_busy), 32'd0);
            check("idle_mem_addr_en", 32'(mem_addr_en), 32'd0);
            check("idle_rdata_vld", 32'(cache_rdata_vld), 32'd0);
        end
        check("reset_cache_rdata", 32'(cache_rdata), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);

        // single write: one pulse, then empty after LAT wait cycles
        base = mem_pulses;
        push_wr(16'hABCD, 8'hAA);
        send(1'b0, 16'hABCD, 8'hAA, w);
        n = 0;
        do begin @(negedge clk); n++; end while (mem_addr_en !== 1'b1 && n < 20);
        check("wr1_pulse_seen", 32'(mem_addr_en), 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (buf_empty === 1'b1 || n >= 20) break;
            n++;
        end
        check("wr1_cycles_until_empty", 32'(n), 32'(LAT));
        repeat (3) @(negedge clk);
        #1;
        check("wr1_pulse_count", 32'(mem_pulses - base), 32'd1);

        // five writes into a four-entry buffer
        base = mem_pulses;
        for (int i = 0; i < 5; i++) push_wr(16'h0010 + 16'(i), 8'h01 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 16'h0010 + 16'(i), 8'h01 + 8'(i), w);
            check("fill_no_wait", 32'(w), 32'd0);
        end
        @(negedge clk);
        check("full_busy", 32'(buf_busy), 32'd1);
        send(1'b0, 16'h0014, 8'h05, w);
        check("fifth_waited", 32'(w > 0), 32'd1);
        check("fifth_after_first_pop", 32'(mem_pulses - base), 32'd1);
        wait_empty("five_drained");
        #1;
        check("five_pulse_count", 32'(mem_pulses - base), 32'd5);

        // forwarding from the youngest duplicate
        base_rd  = mem_rd_pulses;
        base_vld = vld_pulses;
        push_wr(16'h1234, 8'h11);
        push_wr(16'h1234, 8'h22);
        send(1'b0, 16'h1234, 8'h11, w);
        send(1'b0, 16'h1234, 8'h22, w);
        exp_rd_q.push_back(8'h22);
        send(1'b1, 16'h1234, 8'h00, w);
        @(negedge clk);
        check("hit_vld_latency", 32'(cache_rdata_vld), 32'd1);
        check("hit_data", 32'(cache_rdata), 32'h22);
        wait_empty("hit_drained");
        #1;
        check("hit_no_mem_read", 32'(mem_rd_pulses - base_rd), 32'd0);
        check("hit_vld_count", 32'(vld_pulses - base_vld), 32'd1);

        // read miss behind a draining write
        base_rd  = mem_rd_pulses;
        base_vld = vld_pulses;
        push_wr(16'h2000, 8'h77);
        push_rd(16'h5555);
        exp_rd_q.push_back(8'h5A);
        send(1'b0, 16'h2000, 8'h77, w);
        send(1'b1, 16'h5555, 8'h00, w);
        busy_ok = 1'b1;
        n = 0;
        @(negedge clk);
        while (cache_rdata_vld !== 1'b1 && n < 100) begin
            if (buf_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check("miss_vld_seen", 32'(cache_rdata_vld), 32'd1);
        check("miss_busy_throughout", 32'(busy_ok), 32'd1);
        check("miss_rd_after_wr_wait", 32'(last_rd_cyc - last_wr_cyc), 32'(LAT + 2));
        repeat (4) @(negedge clk);
        #1;
        check("miss_single_vld", 32'(vld_pulses - base_vld), 32'd1);
        check("miss_single_mem_read", 32'(mem_rd_pulses - base_rd), 32'd1);
        check("miss_empty_after", 32'(buf_empty), 32'd1);

        // reset during WR_WAIT with three entries queued
        base = mem_pulses;
        for (int i = 0; i < 3; i++) begin
            push_wr(16'h3000 + 16'(i), 8'hC0 + 8'(i));
            send(1'b0, 16'h3000 + 16'(i), 8'hC0 + 8'(i), w);
        end
        check("rst_wr_issued_once", 32'(mem_pulses - base), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_buf_empty", 32'(buf_empty), 32'd1);
        check("rst_buf_busy", 32'(buf_busy), 32'd0);
        check("rst_mem_addr_en", 32'(mem_addr_en), 32'd0);
        rst_n = 1'b1;
        exp_mem_q.delete();
        base = mem_pulses;
        repeat (20) @(negedge clk);
        #1;
        check("rst_no_more_issue", 32'(mem_pulses - base), 32'd0);
        check("rst_still_empty", 32'(buf_empty), 32'd1);

        // reset with a read outstanding; late mem_rdata_vld is ignored
        rsp_delay = 6;
        base_rd   = mem_rd_pulses;
        push_rd(16'h6000);
        send(1'b1, 16'h6000, 8'h00, w);
        n = 0;
        while (mem_rd_pulses == base_rd && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rdrst_read_issued", 32'(mem_rd_pulses - base_rd), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rdrst_buf_empty", 32'(buf_empty), 32'd1);
        check("rdrst_buf_busy", 32'(buf_busy), 32'd0);
        base_vld = vld_pulses;
        repeat (15) @(negedge clk);
        #1;
        check("rdrst_no_vld", 32'(vld_pulses - base_vld), 32'd0);
        check("rdrst_still_empty", 32'(buf_empty), 32'd1);
        rsp_delay = 2;

        check("sb_mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
        check("sb_rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
